// File: rtl/alu_pkg.sv
// Shared definitions for the alu_core datapath: op encoding and compare bit positions.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_NOT   = 4'b0101,
    OP_SLL   = 4'b0110,
    OP_SRA   = 4'b0111,
    OP_SRL   = 4'b1000,
    OP_MUL   = 4'b1001,
    OP_PASSB = 4'b1010,
    OP_SLT   = 4'b1011,
    OP_RSV0  = 4'b1100,
    OP_RSV1  = 4'b1101,
    OP_RSV2  = 4'b1110,
    OP_RSV3  = 4'b1111
  } alu_op_t;

  localparam int CMP_GT = 2;
  localparam int CMP_EQ = 1;
  localparam int CMP_LT = 0;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the issue logic (master) and alu_core (slave).
interface alu_if #(
  parameter int WIDTH = 16
);
  // Valid-only handshake: no ready; the slave accepts A/B/op every cycle in_valid=1,
  // and out/comp are meaningful while out_valid=1, holding their last values otherwise.
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       op;
  logic [WIDTH-1:0] out;
  logic [2:0]       comp;
  logic             out_valid;

  modport master (
    output in_valid, A, B, op,
    input  out, comp, out_valid
  );

  modport slave (
    input  in_valid, A, B, op,
    output out, comp, out_valid
  );
endinterface

// File: rtl/alu_comb.sv
// Combinational result and signed-compare logic for alu_core.
// The multiplier is only built when ALU_MUL_EN is defined; otherwise MUL reads as reserved.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       comp
);

  localparam int SHW = $clog2(WIDTH);

  alu_op_t          op_e;
  logic [SHW-1:0]   shamt;
  logic             lt;
  logic             gt;
  logic [WIDTH-1:0] mul_lo;

  assign op_e  = alu_op_t'(op);
  assign shamt = b[SHW-1:0];
  // Direct signed compare, so sign-boundary cases never depend on a wrapped difference.
  assign lt    = $signed(a) < $signed(b);
  assign gt    = $signed(a) > $signed(b);

`ifdef ALU_MUL_EN
  // The low WIDTH bits of a product are identical for signed and unsigned operands.
  assign mul_lo = a * b;
`else
  assign mul_lo = '0;
`endif

  always_comb begin
    result = '0;
    case (op_e)
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOT:   result = ~a;
      OP_SLL:   result = a << shamt;
      OP_SRA:   result = $signed(a) >>> shamt;
      OP_SRL:   result = a >> shamt;
      OP_MUL:   result = mul_lo;
      OP_PASSB: result = b;
      OP_SLT:   result = {{(WIDTH-1){1'b0}}, lt};
      default:  result = '0;
    endcase
  end

  always_comb begin
    comp         = '0;
    comp[CMP_GT] = gt;
    comp[CMP_EQ] = !gt && !lt;
    comp[CMP_LT] = lt;
  end

endmodule

// File: rtl/alu_core.sv
// Registered 16-bit ALU: one op per cycle, 1-cycle latency, results hold while idle.
// Optional feature macro: ALU_MUL_EN (enables op MUL inside alu_comb).
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  logic [WIDTH-1:0] result;
  logic [2:0]       cmp;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a      (bus.A),
    .b      (bus.B),
    .op     (bus.op),
    .result (result),
    .comp   (cmp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out       <= '0;
      bus.comp      <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out  <= result;
        bus.comp <= cmp;
      end
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vector table, reset/valid sequences, random vs model.
module tb_alu_core;

  localparam int W  = 16;
  localparam int SW = 1 + 3 + W;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_out;
    logic [2:0]  exp_comp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  alu_if #(.WIDTH(W)) bus ();

  alu_core #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-2:0] last_res = '0;

  // Reference model: plain integer arithmetic on sign-extended operands.
  function automatic logic [SW-1:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
    int sa, sb, sh, r;
    logic [2:0] c;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b) % 16;
    case (op)
      4'd0:  r = sa + sb;
      4'd1:  r = sa - sb;
      4'd2:  r = int'(a & b);
      4'd3:  r = int'(a | b);
      4'd4:  r = int'(a ^ b);
      4'd5:  r = ~sa;
      4'd6:  r = sa << sh;
      4'd7:  r = sa >>> sh;
      4'd8:  r = int'({16'h0, a} >> sh);
`ifdef ALU_MUL_EN
      4'd9:  r = sa * sb;
`else
      4'd9:  r = 0;
`endif
      4'd10: r = int'(b);
      4'd11: r = (sa < sb) ? 1 : 0;
      default: r = 0;
    endcase
    if (sa > sb)       c = 3'b100;
    else if (sa == sb) c = 3'b010;
    else               c = 3'b001;
    return {1'b1, c, r[15:0]};
  endfunction

  task automatic check(input string name, input logic [SW-1:0] exp);
    logic [SW-1:0] act;
    act = {bus.out_valid, bus.comp, bus.out};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got valid=%b comp=%b out=%h, expected valid=%b comp=%b out=%h",
               name, act[SW-1], act[SW-2:W], act[W-1:0], exp[SW-1], exp[SW-2:W], exp[W-1:0]);
    end
  endtask

  // Drive one operation at the negedge; the scoreboard entry is checked #1 after the next posedge.
  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op);
    logic [SW-1:0] e;
    @(negedge clk);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.op       = op;
    if (v) begin
      e = model(a, b, op);
      last_res = e[SW-2:0];
    end else begin
      e = {1'b0, last_res};
    end
    exp_q.push_back(e);
  endtask

  task automatic step_check(input string name);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check(name, exp_q.pop_front());
    end
  endtask

  vec_t tbl[$];
  logic [15:0] mul_exp;

  initial begin
`ifdef ALU_MUL_EN
    mul_exp = 16'hFFEE;
`else
    mul_exp = 16'h0000;
`endif
    tbl = '{
      '{"sub_5_2",      4'd1,  16'h0005, 16'h0002, 16'h0003, 3'b100},
      '{"sub_2_5",      4'd1,  16'h0002, 16'h0005, 16'hFFFD, 3'b001},
      '{"sub_5_5",      4'd1,  16'h0005, 16'h0005, 16'h0000, 3'b010},
      '{"sub_m5_m6",    4'd1,  16'hFFFB, 16'hFFFA, 16'h0001, 3'b100},
      '{"sub_m6_m5",    4'd1,  16'hFFFA, 16'hFFFB, 16'hFFFF, 3'b001},
      '{"sub_2_m6",     4'd1,  16'h0002, 16'hFFFA, 16'h0008, 3'b100},
      '{"sub_m6_2",     4'd1,  16'hFFFA, 16'h0002, 16'hFFF8, 3'b001},
      '{"sub_m6_m6",    4'd1,  16'hFFFA, 16'hFFFA, 16'h0000, 3'b010},
      '{"sub_max_min",  4'd1,  16'h7FFF, 16'h8000, 16'hFFFF, 3'b100},
      '{"sll",          4'd6,  16'h0024, 16'h0002, 16'h0090, 3'b100},
      '{"sra",          4'd7,  16'hFFFA, 16'h0001, 16'hFFFD, 3'b001},
      '{"srl",          4'd8,  16'hFFFA, 16'h0001, 16'h7FFD, 3'b001},
      '{"sra_hi_b",     4'd7,  16'hFFFA, 16'hFFF1, 16'hFFFD, 3'b100},
      '{"and",          4'd2,  16'h0F0F, 16'h00FF, 16'h000F, 3'b100},
      '{"or",           4'd3,  16'h0F0F, 16'h00FF, 16'h0FFF, 3'b100},
      '{"xor",          4'd4,  16'h0F0F, 16'h00FF, 16'h0FF0, 3'b100},
      '{"not",          4'd5,  16'h0F0F, 16'h00FF, 16'hF0F0, 3'b100},
      '{"add_wrap",     4'd0,  16'hFFFF, 16'h0001, 16'h0000, 3'b001},
      '{"slt",          4'd11, 16'hFFFA, 16'h0004, 16'h0001, 3'b001},
      '{"reserved",     4'd15, 16'h1234, 16'h1234, 16'h0000, 3'b010},
      '{"mul",          4'd9,  16'hFFFA, 16'h0003, mul_exp,  3'b001},
      '{"passb",        4'd10, 16'h1234, 16'hABCD, 16'hABCD, 3'b100},
      '{"sra_min_15",   4'd7,  16'h8000, 16'h000F, 16'hFFFF, 3'b001},
      '{"sll_1_15",     4'd6,  16'h0001, 16'h000F, 16'h8000, 3'b001}
    };

    // Asynchronous reset with valid traffic present.
    bus.in_valid = 1'b1;
    bus.A        = 16'($urandom);
    bus.B        = 16'($urandom);
    bus.op       = 4'($urandom_range(0, 15));
    #1 rst = 1'b1;
    #2 check("reset_async", '0);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", '0);

    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;

    // Directed table, applied back-to-back.
    foreach (tbl[i]) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.A        = tbl[i].a;
      bus.B        = tbl[i].b;
      bus.op       = tbl[i].op;
      last_res     = {tbl[i].exp_comp, tbl[i].exp_out};
      @(posedge clk);
      #1 check(tbl[i].name, {1'b1, tbl[i].exp_comp, tbl[i].exp_out});
    end

    // in_valid 1,0,1: outputs hold through the idle cycle.
    drive(1'b1, 16'h0005, 16'h0002, 4'd1);
    step_check("valid_on");
    drive(1'b0, 16'h0002, 16'h0005, 4'd0);
    step_check("valid_off_hold");
    drive(1'b1, 16'h0002, 16'h0005, 4'd0);
    step_check("valid_on_again");

    // Reset mid-stream clears immediately and blocks updates.
    drive(1'b1, 16'h1111, 16'h2222, 4'd0);
    step_check("pre_reset");
    #2 rst = 1'b1;
    #1 check("reset_mid_async", '0);
    @(posedge clk);
    #1 check("reset_mid_hold", '0);
    exp_q.delete();
    last_res = '0;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    drive(1'b1, 16'h0003, 16'hFFFA, 4'd0);
    step_check("first_after_reset");

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
      step_check("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Registered 16-bit integer ALU for the datapath execute stage.
- Performs one arithmetic, logic or shift operation per cycle, selected by a 4-bit opcode.
- Also produces a signed three-way comparison of A against B.
- Results are registered, with 1-cycle latency.

Parameters:
- WIDTH, 16, operand and result width in bits. The shift amount uses the low $clog2(WIDTH) bits of B.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and op valid this cycle
- A  input  WIDTH  operand A, two's complement
- B  input  WIDTH  operand B, two's complement
- op  input  4  operation select
- out  output  WIDTH  registered result
- comp  output  3  registered signed compare, {A>B, A==B, A<B}
- out_valid  output  1  out and comp valid

Behaviour:
- Reset (asynchronous, active-high): out=0, comp=3'b000, out_valid=0.
- Latency: on a rising clk edge with in_valid=1, out and comp capture the function of the current A, B and op; out_valid becomes 1 on that same edge.
- With in_valid=0, out and comp hold their values and out_valid becomes 0.
- No backpressure: a new operation can be accepted every cycle.
- Op encoding:
  - 0000 ADD: A+B
  - 0001 SUB: A-B
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOT: ~A
  - 0110 SLL: A << B[3:0]
  - 0111 SRA: arithmetic A >>> B[3:0]
  - 1000 SRL: logical A >> B[3:0]
  - 1001 MUL: low WIDTH bits of A*B (see Optional Feature)
  - 1010 PASSB: B
  - 1011 SLT: 1 if signed A<B, else 0
  - 1100-1111: reserved, out=0
- Arithmetic: ADD and SUB wrap modulo 2^WIDTH. No carry or overflow output.
- Shift amounts use only the low 4 bits of B (0-15); upper bits of B are ignored.
- comp is computed for every op, not only SUB. It is a signed compare of A and B:
  - A>B gives 100
  - A==B gives 010
  - A<B gives 001
  - Exactly one bit is set whenever out_valid=1.
- The signed compare must be correct across sign boundaries, e.g. 2 vs -6 gives 100, and 0x7FFF vs 0x8000 gives 100. Do not derive it from the sign of the wrapped difference alone.
- Reset asserted mid-stream clears all outputs immediately. The first valid result after reset release appears one edge after in_valid is sampled high.

Optional Feature:
- Macro ALU_MUL_EN.
- When defined: op 1001 returns the low WIDTH bits of the signed product A*B.
- When undefined: no multiplier is synthesised, op 1001 behaves as reserved (out=0), and comp is still produced.

Decomposition:
- Shared package alu_pkg holds:
  - the op encoding enum alu_op_t (ADD … SLT, with reserved values)
  - comp bit-position constants CMP_GT=2, CMP_EQ=1, CMP_LT=0
- One natural sub-module, alu_comb: purely combinational result and compare logic.
- alu_core wraps alu_comb with the output registers and the valid register.

Test Plan:
- Reset asserted with in_valid=1 and random operands -> out=0, comp=000, out_valid=0, asynchronously; no update while rst=1.
- op=SUB, in_valid=1, one operand pair per cycle -> one cycle later:
  - A=5, B=2 -> out=0x0003, comp=100
  - A=2, B=5 -> out=0xFFFD, comp=001
  - A=5, B=5 -> out=0x0000, comp=010
- op=SUB with negative operands:
  - A=0xFFFB, B=0xFFFA -> comp=100, out=0x0001
  - A=0xFFFA, B=0xFFFB -> comp=001
  - A=0x0002, B=0xFFFA -> comp=100, out=0x0008
  - A=0xFFFA, B=0x0002 -> comp=001, out=0xFFF8
  - A=0xFFFA, B=0xFFFA -> comp=010
- Shifts:
  - op=SLL, A=0x0024, B=0x0002 -> out=0x0090
  - op=SRA, A=0xFFFA, B=0x0001 -> out=0xFFFD
  - op=SRL, A=0xFFFA, B=0x0001 -> out=0x7FFD
  - op=SRA with B=0xFFF1 (low bits 1) -> same result as B=1
- Logic/misc:
  - A=0x0F0F, B=0x00FF: AND -> 0x000F, OR -> 0x0FFF, XOR -> 0x0FF0, NOT -> 0xF0F0
  - ADD 0xFFFF+1 -> 0x0000
  - SLT A=-6, B=4 -> 0x0001
  - op=1111 -> 0x0000
  - op=MUL, A=0xFFFA, B=0x0003 -> 0xFFEE with ALU_MUL_EN defined, 0x0000 without
- Valid handling: in_valid toggled 1,0,1 -> out_valid follows one cycle later; out and comp hold their values during the in_valid=0 cycle.
